// File: rtl/piso_tx.sv
// Parallel-in serial-out transmitter with a ready/load handshake and back-to-back framing.
// Define PISO_TX_PARITY_EN to append an even-parity bit after the data bits of each frame.
module piso_tx #(
  parameter int WIDTH     = 8,
  parameter int MSB_FIRST = 1
) (
  input  logic             clk,
  input  logic             clear,
  input  logic [WIDTH-1:0] i,
  input  logic             load,
  output logic             ready,
  output logic             o,
  output logic             o_valid,
  output logic             done
);

  localparam int CW = $clog2(WIDTH);

`ifdef PISO_TX_PARITY_EN
  typedef enum logic [1:0] {IDLE, SHIFT, PARITY} state_t;
`else
  typedef enum logic [0:0] {IDLE, SHIFT} state_t;
`endif

  state_t           state, state_n;
  logic [WIDTH-1:0] sr;
  logic [CW-1:0]    cnt;
  logic             last_data;
  logic             accept;
  logic             out_bit;
`ifdef PISO_TX_PARITY_EN
  logic             par;
`endif

  assign last_data = (state == SHIFT) && (cnt == CW'(WIDTH - 1));
  assign accept    = load && ready;
  assign out_bit   = (MSB_FIRST != 0) ? sr[WIDTH-1] : sr[0];

  // NOTE: every output and state_n gets a default before the case so no path leaves them unassigned (no latches).
  always_comb begin
    state_n = state;
    ready   = 1'b0;
    o       = 1'b0;
    o_valid = 1'b0;
    done    = 1'b0;
    case (state)
      IDLE: begin
        ready = 1'b1;
        if (load) state_n = SHIFT;
      end
      SHIFT: begin
        o       = out_bit;
        o_valid = 1'b1;
        if (last_data) begin
`ifdef PISO_TX_PARITY_EN
          state_n = PARITY;
`else
          // Last data bit doubles as the accept window so frames can abut.
          ready   = 1'b1;
          done    = 1'b1;
          state_n = load ? SHIFT : IDLE;
`endif
        end
      end
`ifdef PISO_TX_PARITY_EN
      PARITY: begin
        o       = par;
        o_valid = 1'b1;
        ready   = 1'b1;
        done    = 1'b1;
        state_n = load ? SHIFT : IDLE;
      end
`endif
      default: state_n = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (clear) begin
      state <= IDLE;
      sr    <= '0;
      cnt   <= '0;
`ifdef PISO_TX_PARITY_EN
      par   <= 1'b0;
`endif
    end else begin
      state <= state_n;
      if (accept) begin
        sr  <= i;
        cnt <= '0;
`ifdef PISO_TX_PARITY_EN
        par <= ^i;
`endif
      end else if (state == SHIFT) begin
        sr  <= (MSB_FIRST != 0) ? {sr[WIDTH-2:0], 1'b0} : {1'b0, sr[WIDTH-1:1]};
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule
